phv_egress_buffer: RTL and testbench

- Receiving end of the final-stage PHV output interface (phv_out_0 / phv_out_valid_0 / phv_fifo_ready_0).
- Sits between the last pipeline stage and the deparser. Buffers every valid PHV and presents it through a valid/ready interface.
- Drives phv_fifo_ready early enough to absorb the PHVs still in flight upstream. The upstream drives valid regardless of ready, so this block never stalls it.

---
 rtl/phv_egress_buffer_pkg.sv | 20 ++
 rtl/phv_egress_buffer_ram.sv | 29 ++
 rtl/phv_egress_buffer.sv | 100 ++++++++++
 tb/tb_phv_egress_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/phv_egress_buffer_pkg.sv
// Shared constants and helpers for the PHV egress buffer slice.
package phv_egress_buffer_pkg;

    // Default PHV width: 48*8 + 32*8 + 16*8 + 256 bits.
    localparam int PHV_LEN_DEFAULT = 1024;

    // Number of PHVs that can still be in flight upstream after ready drops.
    localparam int PIPE_INFLIGHT = 4;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return int'(r);
    endfunction

endpackage

// File: rtl/phv_egress_buffer_ram.sv
// DEPTH x W register array: synchronous write, asynchronous read, no reset.
module phv_buf_ram #(
    parameter int W     = 1024,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          axis_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port: store one PHV per enabled cycle.
    always_ff @(posedge axis_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: head entry falls through combinationally.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/phv_egress_buffer.sv
// Egress PHV buffer: FWFT queue with skid-aware ready and drop statistics.
module phv_egress_buffer
    import phv_egress_buffer_pkg::*;
#(
    parameter int PHV_LEN = PHV_LEN_DEFAULT,
    parameter int DEPTH   = 16,
    parameter int SKID    = PIPE_INFLIGHT,
    parameter int CNT_W   = 16
) (
    input  logic                        axis_clk,
    input  logic                        aresetn,
    input  logic [PHV_LEN-1:0]          phv_in,
    input  logic                        phv_in_valid,
    output logic                        phv_fifo_ready,
    output logic [PHV_LEN-1:0]          phv_out,
    output logic                        phv_out_valid,
    input  logic                        phv_out_ready,
    output logic [clog2(DEPTH+1)-1:0]   occupancy,
    output logic                        overflow,
    output logic [CNT_W-1:0]            drop_cnt,
    input  logic                        clr_stats
);

    localparam int AW = clog2(DEPTH);
    localparam int OW = clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL_LVL  = OW'(DEPTH);
    localparam logic [OW-1:0] READY_LIM = OW'(DEPTH - SKID);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ_next;
    logic          do_push;
    logic          do_pop;
    logic          do_drop;

    phv_buf_ram #(
        .W     (PHV_LEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .axis_clk (axis_clk),
        .we       (do_push),
        .waddr    (wr_ptr),
        .wdata    (phv_in),
        .raddr    (rd_ptr),
        .rdata    (phv_out)
    );

    // Handshake decode and next occupancy; a pop frees a slot for a same-cycle push at full.
    always_comb begin
        phv_out_valid = (occupancy != '0);
        do_pop        = phv_out_valid & phv_out_ready;
        do_push       = phv_in_valid & ((occupancy != FULL_LVL) | do_pop);
        do_drop       = phv_in_valid & ~do_push;
        occ_next      = occupancy;
        if (do_push & ~do_pop) begin
            occ_next = occupancy + OW'(1);
        end else if (do_pop & ~do_push) begin
            occ_next = occupancy - OW'(1);
        end
    end

    // Pointers, occupancy and registered ready (DEPTH - occ_next > SKID).
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occupancy      <= '0;
            phv_fifo_ready <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occupancy      <= occ_next;
            phv_fifo_ready <= (occ_next < READY_LIM);
        end
    end

    // Drop statistics; a drop coinciding with clr_stats restarts the count at one.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (do_drop) begin
            overflow <= 1'b1;
            if (clr_stats) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else if (clr_stats) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_phv_egress_buffer.sv
// Scoreboard bench for phv_egress_buffer with a queue-level reference model.
module tb_phv_egress_buffer;

    localparam int PL    = 1024;
    localparam int DEPTH = 16;
    localparam int SKID  = 4;
    localparam int CW    = 16;

    logic            axis_clk = 1'b0;
    logic            aresetn  = 1'b1;
    logic [PL-1:0]   phv_in   = '0;
    logic            phv_in_valid  = 1'b0;
    logic            phv_fifo_ready;
    logic [PL-1:0]   phv_out;
    logic            phv_out_valid;
    logic            phv_out_ready = 1'b0;
    logic [4:0]      occupancy;
    logic            overflow;
    logic [CW-1:0]   drop_cnt;
    logic            clr_stats = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [PL-1:0] exp_q[$];
    int            m_occ   = 0;
    logic          m_ready = 1'b0;
    logic          m_ovf   = 1'b0;
    int            m_drop  = 0;

    phv_egress_buffer #(
        .PHV_LEN (PL),
        .DEPTH   (DEPTH),
        .SKID    (SKID),
        .CNT_W   (CW)
    ) dut (
        .axis_clk       (axis_clk),
        .aresetn        (aresetn),
        .phv_in         (phv_in),
        .phv_in_valid   (phv_in_valid),
        .phv_fifo_ready (phv_fifo_ready),
        .phv_out        (phv_out),
        .phv_out_valid  (phv_out_valid),
        .phv_out_ready  (phv_out_ready),
        .occupancy      (occupancy),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .clr_stats      (clr_stats)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PL-1:0] rnd_phv(input logic [31:0] tag);
        logic [PL-1:0] r;
        r = '0;
        for (int i = 1; i < PL / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        r[31:0] = tag;
        return r;
    endfunction

    // Reference model: a bounded queue with drop accounting, advanced per clock.
    initial forever begin
        @(posedge axis_clk or negedge aresetn);
        if (!aresetn) begin
            exp_q.delete();
            m_occ   = 0;
            m_ready = 1'b0;
            m_ovf   = 1'b0;
            m_drop  = 0;
        end else begin
            bit pop;
            bit push;
            pop  = (m_occ > 0) && phv_out_ready;
            push = phv_in_valid && ((m_occ < DEPTH) || pop);
            if (push) begin
                exp_q.push_back(phv_in);
                m_occ = m_occ + 1;
            end
            if (pop) begin
                m_occ = m_occ - 1;
            end
            if (phv_in_valid && !push) begin
                m_ovf  = 1'b1;
                m_drop = clr_stats ? 1 : ((m_drop < 65535) ? m_drop + 1 : m_drop);
            end else if (clr_stats) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            m_ready = (DEPTH - m_occ) > SKID;
        end
    end

    // Monitor: checks status every cycle and consumes the scoreboard on each accepted output.
    initial forever begin
        @(negedge axis_clk);
        check("occupancy", 64'(occupancy), 64'(m_occ));
        check("out_valid", 64'(phv_out_valid), 64'(m_occ != 0));
        check("fifo_ready", 64'(phv_fifo_ready), 64'(m_ready));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (aresetn && phv_out_valid && phv_out_ready) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL phv_out: unexpected output %0h, scoreboard empty", phv_out[63:0]);
            end else begin
                logic [PL-1:0] e;
                e = exp_q.pop_front();
                total = total + 1;
                if (phv_out !== e) begin
                    bad = bad + 1;
                    $display("FAIL phv_out: got %0h expected %0h (low 64 bits)", phv_out[63:0], e[63:0]);
                end
            end
        end
    end

    // One stimulus cycle: inputs change 2 time units after the active edge.
    task automatic cyc(input logic v, input logic [31:0] tag, input logic rdy, input logic clr);
        phv_in_valid  = v;
        phv_in        = rnd_phv(tag);
        phv_out_ready = rdy;
        clr_stats     = clr;
        @(posedge axis_clk);
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (phv_out_valid && n < 40) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            n = n + 1;
        end
        check("drain_done", 64'(phv_out_valid), 64'(0));
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 aresetn = 1'b0;
        #2;
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_valid", 64'(phv_out_valid), 64'(0));
        check("rst_ready", 64'(phv_fifo_ready), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        @(posedge axis_clk); @(posedge axis_clk);
        #2 aresetn = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("release_ready", 64'(phv_fifo_ready), 64'(1));

        // Three single PHVs with the deparser always ready.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'hA + 32'(i), 1'b1, 1'b0);
            check("single_visible", 64'(phv_out[31:0]), 64'(32'hA + 32'(i)));
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            check("single_occ", 64'(occupancy), 64'(0));
        end

        // Twelve back-to-back pushes: ready falls with the twelfth.
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            if (i == 11) check("ready_at_11", 64'(phv_fifo_ready), 64'(1));
        end
        check("ready_at_12", 64'(phv_fifo_ready), 64'(0));
        check("occ_12", 64'(occupancy), 64'(12));
        drain();

        // Eighteen pushes ignoring ready: two drops.
        for (int i = 1; i <= 18; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
        end
        check("occ_full", 64'(occupancy), 64'(16));
        check("ovf_full", 64'(overflow), 64'(1));
        check("drop_2", 64'(drop_cnt), 64'(2));

        // Push and pop together at full: accepted, not dropped.
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        check("full_pushpop_occ", 64'(occupancy), 64'(16));
        check("full_pushpop_drop", 64'(drop_cnt), 64'(2));
        drain();

        // Asynchronous reset mid-cycle with seven entries queued.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        end
        check("occ_7", 64'(occupancy), 64'(7));
        #1 aresetn = 1'b0;
        #1;
        check("async_valid", 64'(phv_out_valid), 64'(0));
        check("async_occ", 64'(occupancy), 64'(0));
        check("async_ready", 64'(phv_fifo_ready), 64'(0));
        @(posedge axis_clk);
        #2 aresetn = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("rerelease_ready", 64'(phv_fifo_ready), 64'(1));
        check("rerelease_valid", 64'(phv_out_valid), 64'(0));

        // Three drops, then clr_stats colliding with a drop, then a plain clear.
        for (int i = 0; i < 19; i++) begin
            cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        end
        check("drop_3", 64'(drop_cnt), 64'(3));
        cyc(1'b1, 32'h3FF, 1'b0, 1'b1);
        check("clr_drop_ovf", 64'(overflow), 64'(1));
        check("clr_drop_cnt", 64'(drop_cnt), 64'(1));
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check("clr_ovf", 64'(overflow), 64'(0));
        check("clr_cnt", 64'(drop_cnt), 64'(0));
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 49) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
